// File: rtl/matmul_if.sv
// Handshake and memory/MAC strobes between the top-level controller and the matmul sequencer.
interface matmul_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic [3:0]        matrix_size;
    logic              rd_en;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic              mac_en;
    logic              mac_clr;
    logic              wr_c;
    logic [ADDR_W-1:0] addr_c;
    logic              busy;
    logic              done;
    logic              size_err;

    modport master (
        output start, matrix_size,
        input  rd_en, addr_a, addr_b, mac_en, mac_clr, wr_c, addr_c, busy, done, size_err
    );

    modport slave (
        input  start, matrix_size,
        output rd_en, addr_a, addr_b, mac_en, mac_clr, wr_c, addr_c, busy, done, size_err
    );
endinterface

// File: rtl/matmul_scheduler.sv
// Walks (i, j, k) of C = A x B, issuing operand reads, MAC clear/enable and result writes.
module matmul_scheduler #(
    parameter int MAX_N  = 8,
    parameter int ADDR_W = 6
) (
    input  logic     clk,
    input  logic     rst,
    matmul_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [3:0] MAX_N4 = 4'(MAX_N);

    state_t            state, state_nxt;
    logic [3:0]        n_q, i_q, j_q, k_q;
    logic              drain_q, err_q;
    logic [ADDR_W-1:0] a_q, b_q, row_q, c1_q, c_q;
    logic              mac_en_q, mac_clr_q, wr1_q, wr_q;
    logic              size_ok, k_last, j_last, i_last, run_last, rd;
    logic [ADDR_W-1:0] n_ext;

    assign size_ok  = (bus.matrix_size != 4'd0) && (bus.matrix_size <= MAX_N4);
    assign k_last   = (k_q == n_q - 4'd1);
    assign j_last   = (j_q == n_q - 4'd1);
    assign i_last   = (i_q == n_q - 4'd1);
    assign run_last = k_last && j_last && i_last;
    assign n_ext    = ADDR_W'(n_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd        = 1'b0;
        case (state)
            IDLE:  if (bus.start) state_nxt = size_ok ? RUN : DONE;
            RUN: begin
                rd = 1'b1;
                if (run_last) state_nxt = DRAIN;
            end
            DRAIN: if (drain_q) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            row_q     <= '0;
            c1_q      <= '0;
            c_q       <= '0;
            mac_en_q  <= 1'b0;
            mac_clr_q <= 1'b0;
            wr1_q     <= 1'b0;
            wr_q      <= 1'b0;
            drain_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            mac_en_q  <= rd;
            mac_clr_q <= rd && (k_q == 4'd0);
            wr1_q     <= rd && k_last;
            wr_q      <= wr1_q;
            drain_q   <= (state == DRAIN) && !drain_q;
            if (rd && k_last) c1_q <= row_q + ADDR_W'(j_q);
            if (wr1_q) c_q <= c1_q;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        n_q   <= bus.matrix_size;
                        err_q <= !size_ok;
                        if (size_ok) begin
                            i_q   <= '0;
                            j_q   <= '0;
                            k_q   <= '0;
                            a_q   <= '0;
                            b_q   <= '0;
                            row_q <= '0;
                        end
                    end
                end
                RUN: begin
                    // Counters freeze on the last read so the address outputs hold it.
                    if (!run_last) begin
                        if (!k_last) begin
                            k_q <= k_q + 4'd1;
                            a_q <= a_q + ADDR_W'(1);
                            b_q <= b_q + n_ext;
                        end else begin
                            k_q <= '0;
                            if (!j_last) begin
                                j_q <= j_q + 4'd1;
                                a_q <= row_q;
                                b_q <= ADDR_W'(j_q + 4'd1);
                            end else begin
                                j_q   <= '0;
                                i_q   <= i_q + 4'd1;
                                row_q <= row_q + n_ext;
                                a_q   <= row_q + n_ext;
                                b_q   <= '0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_en    = rd;
    assign bus.addr_a   = a_q;
    assign bus.addr_b   = b_q;
    assign bus.mac_en   = mac_en_q;
    assign bus.mac_clr  = mac_clr_q;
    assign bus.wr_c     = wr_q;
    assign bus.addr_c   = c_q;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.size_err = (state == DONE) && err_q;
endmodule

// File: tb/tb_matmul_scheduler.sv
// Directed bench for matmul_scheduler: per-cycle comparison against closed-form index formulas.
module tb_matmul_scheduler;
    localparam int MAX_N  = 8;
    localparam int ADDR_W = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matmul_if #(.ADDR_W(ADDR_W)) bus ();

    matmul_scheduler #(.MAX_N(MAX_N), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] size;
        int         reads;
        int         writes;
        int         done_cyc;
    } vec_t;

    vec_t vecs [8];

    int checks = 0;
    int errors = 0;
    int n_rd, n_wr;
    logic [ADDR_W-1:0] exp_a, exp_b, exp_c;

    function automatic logic [24:0] snap();
        return {bus.rd_en, bus.mac_en, bus.mac_clr, bus.wr_c, bus.busy, bus.done,
                bus.size_err, bus.addr_a, bus.addr_b, bus.addr_c};
    endfunction

    task automatic check_vec(input string name, input int cyc, input logic [24:0] act,
                             input logic [24:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h (rd,me,mc,wr,busy,done,serr,a,b,c)",
                     name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Edge 0 (start accepted) has just passed. Checks cycles 1..done+1, or 1..stop_c,
    // in which case it returns before the edge of stop_c.
    task automatic trace(input logic [3:0] sz, input bit toggle, input logic [3:0] next_sz,
                         input int stop_c);
        bit err;
        int n, n3, done_c, last, t;
        bit rd, me, mc, wr, bz, dn, se;
        err    = (sz == 4'd0) || (int'(sz) > MAX_N);
        n      = err ? 1 : int'(sz);
        n3     = err ? 0 : n * n * n;
        done_c = err ? 1 : n3 + 3;
        last   = (stop_c > 0) ? stop_c : done_c + 1;
        n_rd   = 0;
        n_wr   = 0;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            rd = !err && (c <= n3);
            if (rd) begin
                t     = c - 1;
                exp_a = ADDR_W'((t / (n * n)) * n + (t % n));
                exp_b = ADDR_W'((t % n) * n + ((t / n) % n));
            end
            me = !err && (c >= 2) && (c <= n3 + 1);
            mc = me && (((c - 2) % n) == 0);
            wr = !err && (c >= n + 2) && (c <= n3 + 2) && (((c - 2) % n) == 0);
            if (wr) exp_c = ADDR_W'((c - 2) / n - 1);
            bz = (c <= done_c);
            dn = (c == done_c);
            se = err && (c == 1);
            if (bus.rd_en) n_rd++;
            if (bus.wr_c) n_wr++;
            check_vec("cycle", c, snap(), {rd, me, mc, wr, bz, dn, se, exp_a, exp_b, exp_c});
            if (toggle)
                bus.matrix_size = (c >= done_c - 1) ? next_sz : (((c % 2) == 1) ? 4'd9 : 4'd5);
            if (c != stop_c) @(posedge clk);
        end
    endtask

    initial begin
        vecs[0] = '{4'd1,  1,   1,  4};
        vecs[1] = '{4'd2,  8,   4,  11};
        vecs[2] = '{4'd0,  0,   0,  1};
        vecs[3] = '{4'd9,  0,   0,  1};
        vecs[4] = '{4'd3,  27,  9,  30};
        vecs[5] = '{4'd8,  512, 64, 515};
        vecs[6] = '{4'd15, 0,   0,  1};
        vecs[7] = '{4'd5,  125, 25, 128};

        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.matrix_size = 4'd0;
        exp_a = '0;
        exp_b = '0;
        exp_c = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_vec("reset", 0, snap(), '0);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            bus.start       = 1'b1;
            bus.matrix_size = vecs[v].size;
            @(posedge clk);
            #1;
            bus.start       = 1'b0;
            bus.matrix_size = 4'd7;
            trace(vecs[v].size, 1'b0, 4'd0, 0);
            check_int("reads", n_rd, vecs[v].reads);
            check_int("writes", n_wr, vecs[v].writes);
        end

        // start held high, matrix_size wiggling mid-run; second run picks up N = 2.
        @(negedge clk);
        bus.start       = 1'b1;
        bus.matrix_size = 4'd3;
        @(posedge clk);
        trace(4'd3, 1'b1, 4'd2, 0);
        check_int("held_reads", n_rd, 27);
        check_int("held_writes", n_wr, 9);
        #1;
        bus.start       = 1'b0;
        bus.matrix_size = 4'd6;
        trace(4'd2, 1'b0, 4'd0, 0);
        check_int("rerun_reads", n_rd, 8);
        check_int("rerun_writes", n_wr, 4);

        // Reset in the middle of an N = 4 run.
        @(negedge clk);
        bus.start       = 1'b1;
        bus.matrix_size = 4'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        trace(4'd4, 1'b0, 4'd0, 10);
        rst   = 1'b1;
        exp_a = '0;
        exp_b = '0;
        exp_c = '0;
        @(posedge clk);
        @(negedge clk);
        check_vec("mid_reset", 11, snap(), '0);
        rst = 1'b0;
        for (int c = 12; c < 18; c++) begin
            @(negedge clk);
            check_vec("post_reset", c, snap(), '0);
        end

        @(negedge clk);
        bus.start       = 1'b1;
        bus.matrix_size = 4'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        trace(4'd2, 1'b0, 4'd0, 0);
        check_int("after_reset_reads", n_rd, 8);
        check_int("after_reset_writes", n_wr, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/matmul_scheduler.md
# matmul_scheduler

Sequencer for the matrix-multiply datapath. On a start command it walks the index space (i, j, k) of C = A×B for an N×N problem. It issues one read per cycle to the A and B operand memories, drives clear/enable to the external multiply-accumulate unit, and writes each finished C element to the result memory. It sits between the top-level control FSM (start, done) and the operand memories, MAC, and result memory.

## Interface

Parameters:
- MAX_N, 8: largest supported matrix dimension.
- ADDR_W, 6: memory address width. Must satisfy 2^ADDR_W ≥ MAX_N².

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request. Sampled only in IDLE.
- matrix_size  in  4  N. Latched on the cycle start is accepted.
- rd_en  out  1  read strobe to the A and B memories.
- addr_a  out  ADDR_W  A address, i·N + k.
- addr_b  out  ADDR_W  B address, k·N + j.
- mac_en  out  1  MAC accumulate enable. Operand data is valid this cycle.
- mac_clr  out  1  with mac_en: load the product instead of accumulating (k = 0).
- wr_c  out  1  result memory write strobe. MAC output is valid this cycle.
- addr_c  out  ADDR_W  C address, i·N + j.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle completion pulse.
- size_err  out  1  one-cycle pulse, coincident with done, when N is invalid.

## Operation

- States: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN: start = 1 and 1 ≤ matrix_size ≤ MAX_N. Latch N; i = j = k = 0.
- IDLE → DONE: start = 1 and matrix_size = 0 or > MAX_N. Also pulse size_err. No reads or writes are issued.
- RUN: rd_en = 1 every cycle with the current (i, j, k).
  - k increments first, then j, then i.
  - The cycle issuing (N−1, N−1, N−1) is the last RUN cycle; next state is DRAIN.
- DRAIN: exactly 2 cycles, to flush the pipeline. Then go to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- Pipeline:
  - mac_en is rd_en delayed 1 cycle. mac_clr is (rd_en ∧ k = 0) delayed 1 cycle.
  - wr_c is (rd_en ∧ k = N−1) delayed 2 cycles. addr_c is i·N + j of that read, delayed 2 cycles.
- No bubbles between elements: wr_c for element e coincides with mac_en + mac_clr for element e+1. C captures the MAC's registered old sum on that same edge.
- Address arithmetic:
  - Unsigned. Maximum value is MAX_N² − 1, so no overflow.
  - Generate addresses with incremental counters and row bases; no multiplier.
- Ignored inputs:
  - start while busy is ignored.
  - matrix_size changes after latching are ignored.
- Reset (any state, including mid-run): on the next edge, state = IDLE and every output and internal pipeline register is 0. No further wr_c is issued.

## Timing

- Reset values: rd_en, mac_en, mac_clr, wr_c, busy, done, size_err = 0; addr_a, addr_b, addr_c = 0.
- Address outputs hold their last value while their strobe is low.
- Let cycle 0 be the edge where start is accepted:
  - RUN spans cycles 1 … N³. rd_en is high throughout.
  - mac_en is high on cycles 2 … N³+1.
  - For element e (0-based, e = i·N + j), wr_c fires at cycle (e+1)·N + 2. The last write is at N³ + 2.
  - DRAIN spans cycles N³+1 and N³+2.
  - done is at cycle N³+3.
  - IDLE resumes at N³+4. A new start is accepted there at the earliest.
- Error path: done and size_err both fire at cycle 1. IDLE resumes at cycle 2.
- busy is high from cycle 1 through the done cycle inclusive.

## Test plan

- N = 1, start pulse:
  - rd_en at cycle 1 only, addr_a = addr_b = 0.
  - mac_en + mac_clr at cycle 2.
  - wr_c at cycle 3 with addr_c = 0.
  - done at cycle 4.
- N = 2:
  - 8 reads on cycles 1–8. addr_a sequence is 0,1,0,1,2,3,2,3; addr_b sequence is 0,2,1,3,0,2,1,3.
  - wr_c at cycles 4, 6, 8, 10 with addr_c 0, 1, 2, 3.
  - mac_clr at cycles 2, 4, 6, 8.
  - done at cycle 11.
- matrix_size = 0, and separately matrix_size = 9:
  - done and size_err both at cycle 1.
  - rd_en and wr_c never asserted. busy high for 1 cycle.
- N = 3, with start held high and matrix_size toggled during the run:
  - Exactly 27 reads, 9 writes, done at cycle 30.
  - Second run begins at cycle 31 with the matrix_size value present at cycle 30.
- N = 4, rst asserted at cycle 10:
  - All outputs 0 from cycle 11. No wr_c after cycle 10.
  - A fresh start with N = 2 completes with the N = 2 timing above.
- N = MAX_N = 8:
  - 512 reads. Final addr_a = addr_b = 63. Last wr_c at cycle 514 with addr_c = 63.
  - done at cycle 515.
